// File: rtl/press_judge_pkg.sv
// -----------------------------------------------------------------------------
// press_judge_pkg
// Shared definitions for the countdown-game player judge:
//   - state_t          : judge FSM state encoding (2-bit)
//   - DEBOUNCE_CYC_DEF : default key stability window in clock cycles
//                        (20 cycles = 20 ms at the 1 kHz game clock)
//   - CNT_W_DEF        : default width of the press counter and target
// -----------------------------------------------------------------------------
package press_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_JUDGE  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYC_DEF = 20;
  localparam int CNT_W_DEF        = 3;

endpackage

// File: rtl/press_judge_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Front-panel key conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on each debounced rising edge.
// A level change is accepted only after DEBOUNCE_CYC consecutive cycles in
// which the synchronized key disagrees with the debounced level.
//
// Ports:
//   clk   in  1 : system clock
//   rst   in  1 : asynchronous active-high reset (debounced level -> 0)
//   key   in  1 : raw, asynchronous, bouncy key (active-high)
//   press out 1 : one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module key_debounce
  import press_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam int             CW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] stab_cnt;

  // Stage p0/p1: synchronizer; the stability counter then judges sync_p1.
  // The flip happens on the DEBOUNCE_CYC-th disagreeing cycle, so the counter
  // only needs to reach DEBOUNCE_CYC-1 before the edge that flips the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level    <= 1'b0;
      stab_cnt <= '0;
      press    <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == level) begin
        stab_cnt <= '0;
      end else if (stab_cnt == LAST) begin
        level    <= sync_p1;
        stab_cnt <= '0;
        press    <= sync_p1;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/press_judge.sv
// -----------------------------------------------------------------------------
// press_judge
// Player-side judge for the countdown game. While a round is armed it counts
// debounced key presses (saturating); when the countdown raises `over` it
// compares the count with `target` and reports win or lose until the round
// is cleared by `cst` going low.
//
// Ports:
//   clk       in  1     : 1 kHz system clock (shared with countdown counter)
//   rst       in  1     : asynchronous active-high reset
//   cst       in  1     : round control, active-low clear; 0->1 arms a round
//   over      in  1     : countdown expired (level)
//   key       in  1     : raw player button
//   target    in  CNT_W : required press count, sampled in JUDGE
//   press_cnt out CNT_W : debounced presses counted this round
//   busy      out 1     : round armed
//   win       out 1     : result, count matched target
//   lose      out 1     : result, count differed from target
// -----------------------------------------------------------------------------
module press_judge
  import press_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cst,
  input  logic             over,
  input  logic             key,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t next_state;
  logic   cst_d;
  logic   press;
  logic   win_r;
  logic   lose_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .press(press)
  );

  // State register and cst edge-detect copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cst_d <= 1'b0;
    end else begin
      state <= next_state;
      cst_d <= cst;
    end
  end

  // Next-state logic; a low cst aborts the round from any state.
  always_comb begin
    next_state = state;
    if (!cst) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (!cst_d) next_state = ST_ARMED;
        ST_ARMED:  if (over)   next_state = ST_JUDGE;
        ST_JUDGE:  next_state = ST_RESULT;
        ST_RESULT: next_state = ST_RESULT;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  // Press counter and result registers. A press arriving on the same cycle
  // as `over` is still counted because ARMED is the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_cnt <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
    end else if (!cst) begin
      press_cnt <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          press_cnt <= '0;
          win_r     <= 1'b0;
          lose_r    <= 1'b0;
        end
        ST_ARMED: begin
          if (press) press_cnt <= sat_inc(press_cnt);
        end
        ST_JUDGE: begin
          win_r  <= (press_cnt == target);
          lose_r <= (press_cnt != target);
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs; result flags are gated so they can only show in RESULT.
  always_comb begin
    busy = (state == ST_ARMED);
    win  = win_r  && (state == ST_RESULT);
    lose = lose_r && (state == ST_RESULT);
  end

endmodule
